alu: RTL and testbench



---
 rtl/alu.sv | 56 +++++
 tb/tb_alu.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 4-bit, 8-operation ALU with a single registered result.
// The next result is formed combinationally from (oc, a, b) and captured on each rising edge.
module alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] oc,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] out
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b111;

    logic [3:0] result;
    logic [7:0] product;
    logic [3:0] quotient;

    assign product = {4'b0000, a} * {4'b0000, b};

    // Divide by zero saturates to all ones rather than trapping.
    always_comb begin
        quotient = '1;
        if (b != 4'd0)
            quotient = a / b;
    end

    always_comb begin
        result = '0;
        unique case (oc)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = product[3:0];
            OP_DIV:  result = quotient;
            OP_NOT:  result = ~a;
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out <= '0;
        else
            out <= result;
    end

endmodule

// File: tb/tb_alu.sv
// Directed and exhaustive self-checking bench for the registered 4-bit ALU.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] oc  = 3'b000;
    logic [3:0] a   = 4'd0;
    logic [3:0] b   = 4'd0;
    logic [3:0] out;

    int unsigned total = 0;
    int unsigned bad   = 0;

    alu dut (
        .clk (clk),
        .rst (rst),
        .oc  (oc),
        .a   (a),
        .b   (b),
        .out (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Independent reference: division by repeated subtraction, product via integer math.
    function automatic logic [3:0] model(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        int unsigned r;
        int unsigned q;
        int unsigned p;
        case (op)
            3'd0: model = 4'((int'(x) + int'(y)) % 16);
            3'd1: model = 4'((int'(x) + 16 - int'(y)) % 16);
            3'd2: begin
                p = int'(x) * int'(y);
                model = 4'(p % 16);
            end
            3'd3: begin
                if (y == 4'd0) begin
                    model = 4'hF;
                end else begin
                    r = x;
                    q = 0;
                    while (r >= y) begin
                        r = r - y;
                        q++;
                    end
                    model = 4'(q);
                end
            end
            3'd4: model = 4'(15 - int'(x));
            3'd5: model = x ^ y;
            3'd6: model = x & y;
            default: model = x | y;
        endcase
    endfunction

    task automatic apply(input string tag, input logic [2:0] op, input logic [3:0] x,
                         input logic [3:0] y, input logic [3:0] exp);
        @(negedge clk);
        oc = op;
        a  = x;
        b  = y;
        @(posedge clk);
        #1;
        check(tag, out, exp);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check("reset_initial", out, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        apply("add_wrap",   3'b000, 4'd7,  4'd9,  4'h0);
        apply("sub_wrap",   3'b001, 4'd3,  4'd5,  4'hE);
        apply("mul_35",     3'b010, 4'd5,  4'd7,  4'h3);
        apply("mul_15x15",  3'b010, 4'd15, 4'd15, 4'h1);
        apply("div_13_4",   3'b011, 4'd13, 4'd4,  4'h3);
        apply("div_4_13",   3'b011, 4'd4,  4'd13, 4'h0);
        apply("div_by_0",   3'b011, 4'd9,  4'd0,  4'hF);
        apply("not",        3'b100, 4'b1100, 4'b1010, 4'b0011);
        apply("xor",        3'b101, 4'b1100, 4'b1010, 4'b0110);
        apply("and",        3'b110, 4'b1100, 4'b1010, 4'b1000);
        apply("or",         3'b111, 4'b1100, 4'b1010, 4'b1110);

        // Inputs changed mid-cycle must not reach out before the next edge.
        apply("pre_glitch", 3'b000, 4'd1, 4'd1, 4'h2);
        #2;
        oc = 3'b111; a = 4'hF; b = 4'h0;
        #1 check("glitch_hold", out, 4'h2);
        @(posedge clk);
        #1 check("glitch_load", out, 4'hF);

        // Reset asserted mid-cycle with out = 7.
        apply("pre_reset", 3'b000, 4'd3, 4'd4, 4'h7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("reset_async", out, 4'h0);
        @(posedge clk);
        #1 check("reset_hold1", out, 4'h0);
        @(posedge clk);
        #1 check("reset_hold2", out, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        oc = 3'b000; a = 4'd2; b = 4'd3;
        @(posedge clk);
        #1 check("reset_release", out, 4'h5);

        // Reset coinciding with a clock edge resolves to reset.
        apply("pre_race", 3'b010, 4'd3, 4'd3, 4'h9);
        @(negedge clk);
        oc = 3'b111; a = 4'hF; b = 4'hF;
        @(posedge clk);
        rst = 1'b1;
        #1 check("reset_race", out, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive sweep, one new vector every cycle.
        for (int i = 0; i < 2048; i++) begin
            logic [10:0] v;
            v = 11'(i);
            apply("sweep", v[10:8], v[7:4], v[3:0], model(v[10:8], v[7:4], v[3:0]));
        end

        // Held inputs keep out stable.
        apply("stable0", 3'b101, 4'h9, 4'h3, 4'hA);
        @(posedge clk);
        #1 check("stable1", out, 4'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
